// File: rtl/clk_div_sel_pkg.sv
// clk_div_sel_pkg: shared constants, selection index type and the
// range clamp used by the clk_div_sel divider/selector.
package clk_div_sel_pkg;

    localparam int CLK_DIV_SEL_MAX_SEL = 16;
    localparam int SEL_IDX_W = $clog2(CLK_DIV_SEL_MAX_SEL);

    typedef logic [SEL_IDX_W-1:0] sel_idx_t;

    // Out-of-range requests select the slowest available ratio.
    function automatic sel_idx_t clk_div_sel_clamp(
        input int unsigned sel,
        input int unsigned num_sel
    );
        if (sel >= num_sel) begin
            return sel_idx_t'(num_sel - 1);
        end
        return sel_idx_t'(sel);
    endfunction

endpackage

// File: rtl/clk_div_sel_cnt.sv
// clk_div_sel_cnt: free-running period counter with boundary detect.
// Ports: pclk, presetn (async, active low), run (count enable),
//   clr (sync clear, wins over run), sel_act (active ratio index),
//   cnt (counter value), boundary (run and cnt[sel_act:0] all ones).
module clk_div_sel_cnt
    import clk_div_sel_pkg::*;
#(
    parameter int NUM_SEL = 4
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 run,
    input  logic                 clr,
    input  logic [SEL_IDX_W-1:0] sel_act,
    output logic [NUM_SEL-1:0]   cnt,
    output logic                 boundary
);

    logic [NUM_SEL-1:0] mask;

    // Bits 0..sel_act form the current period's phase counter.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            mask[i] = (i <= int'(sel_act));
        end
    end

    assign boundary = run && ((cnt & mask) == mask);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + NUM_SEL'(1);
        end
    end

endmodule

// File: rtl/clk_div_sel.sv
// clk_div_sel: glitch-free power-of-two clock divider/selector, ratio
// 2^(sel+1); sel/en changes take effect only at period boundaries.
// Ports: pclk, presetn (async, active low), en, sel, clk_out (50%
//   duty, registered), busy (request pending), div_stb (period-end
//   strobe, present only when CLK_DIV_SEL_STB_EN is defined).
module clk_div_sel
    import clk_div_sel_pkg::*;
#(
    parameter int NUM_SEL = 4,
    parameter int SEL_W   = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic             clk_out,
    output logic             busy
`ifdef CLK_DIV_SEL_STB_EN
    ,
    output logic             div_stb
`endif
);

    sel_idx_t           sel_req;
    sel_idx_t           sel_act;
    logic               en_req;
    logic               en_act;
    logic               pending;
    logic               apply;
    logic               boundary;
    logic               nxt_bit;
    logic [NUM_SEL-1:0] cnt;
    logic [NUM_SEL-1:0] cnt_inc;

    assign pending = (sel_req != sel_act) || (en_req != en_act);

    // While stopped there is no period to finish, so apply at once.
    assign apply = pending && (!en_act || boundary);

    assign cnt_inc = cnt + NUM_SEL'(1);

    // clk_out mirrors cnt[sel_act] one edge ahead, keeping it a flop.
    always_comb begin
        nxt_bit = 1'b0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (i == int'(sel_act)) begin
                nxt_bit = cnt_inc[i];
            end
        end
    end

    clk_div_sel_cnt #(
        .NUM_SEL (NUM_SEL)
    ) u_cnt (
        .pclk     (pclk),
        .presetn  (presetn),
        .run      (en_act),
        .clr      (apply || !en_act),
        .sel_act  (sel_act),
        .cnt      (cnt),
        .boundary (boundary)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sel_req <= '0;
            en_req  <= 1'b0;
            sel_act <= '0;
            en_act  <= 1'b0;
            busy    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            sel_req <= clk_div_sel_clamp(32'(sel), NUM_SEL);
            en_req  <= en;
            busy    <= pending;
            if (apply) begin
                sel_act <= sel_req;
                en_act  <= en_req;
                clk_out <= 1'b0;
            end else if (en_act) begin
                clk_out <= nxt_bit;
            end else begin
                clk_out <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_SEL_STB_EN
    assign div_stb = boundary;
`endif

endmodule

// File: tb/tb_clk_div_sel.sv
// tb_clk_div_sel: directed bench for clk_div_sel (NUM_SEL=4 main
// instance, NUM_SEL=3 instance for out-of-range clamping).
module tb_clk_div_sel;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [1:0]  sel_a = 2'd0;
    logic [1:0]  sel_b = 2'd0;
    logic        ca;
    logic        cb;
    logic        busy_a;
    logic        busy_b;
`ifdef CLK_DIV_SEL_STB_EN
    logic        stb_a;
    logic        stb_b;
`endif
    logic [15:0] clk_v;
    logic [15:0] busy_v;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 pclk = ~pclk;

    clk_div_sel #(.NUM_SEL(4)) dut_a (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (en_a),
        .sel     (sel_a),
        .clk_out (ca),
        .busy    (busy_a)
`ifdef CLK_DIV_SEL_STB_EN
        ,
        .div_stb (stb_a)
`endif
    );

    clk_div_sel #(.NUM_SEL(3)) dut_b (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (en_b),
        .sel     (sel_b),
        .clk_out (cb),
        .busy    (busy_b)
`ifdef CLK_DIV_SEL_STB_EN
        ,
        .div_stb (stb_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic collect(input int n);
        clk_v  = '0;
        busy_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            clk_v  = {clk_v[14:0], ca};
            busy_v = {busy_v[14:0], busy_a};
        end
    endtask

    task automatic wait_fall(input string tag);
        int   guard;
        logic prev;
        guard = 0;
        prev  = ca;
        forever begin
            @(negedge pclk);
            guard++;
            if ((prev && !ca) || guard > 100) break;
            prev = ca;
        end
        check({tag, "_to"}, 32'(guard <= 100), 32'd1);
    endtask

    task automatic measure(input string tag, input bit use_b,
                           input int half);
        int   guard;
        int   hi;
        int   lo;
        int   stbs;
        logic prev;
        logic cur;
        logic s;
        logic last_s;
        guard  = 0;
        hi     = 0;
        lo     = 0;
        stbs   = 0;
        last_s = 1'b0;
        prev   = use_b ? cb : ca;
        forever begin
            @(negedge pclk);
            guard++;
            cur = use_b ? cb : ca;
            if ((!prev && cur) || guard > 200) break;
            prev = cur;
        end
        while (guard <= 200) begin
            cur = use_b ? cb : ca;
            if (!cur) break;
`ifdef CLK_DIV_SEL_STB_EN
            s = use_b ? stb_b : stb_a;
`else
            s = 1'b0;
`endif
            hi++;
            stbs += int'(s);
            last_s = s;
            @(negedge pclk);
            guard++;
        end
        while (guard <= 200) begin
            cur = use_b ? cb : ca;
            if (cur) break;
`ifdef CLK_DIV_SEL_STB_EN
            s = use_b ? stb_b : stb_a;
`else
            s = 1'b0;
`endif
            lo++;
            stbs += int'(s);
            @(negedge pclk);
            guard++;
        end
        check({tag, "_to"}, 32'(guard <= 200), 32'd1);
        check({tag, "_hi"}, 32'(hi), 32'(half));
        check({tag, "_lo"}, 32'(lo), 32'(half));
`ifdef CLK_DIV_SEL_STB_EN
        check({tag, "_stbs"}, 32'(stbs), 32'd1);
        check({tag, "_stbpos"}, 32'(last_s), 32'd1);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_clk;
        logic any_stb;

        repeat (2) @(negedge pclk);
        check("rst_clk", 32'(ca), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
`ifdef CLK_DIV_SEL_STB_EN
        check("rst_stb", 32'(stb_a), 32'd0);
`endif

        presetn = 1'b1;
        en_a    = 1'b1;
        sel_a   = 2'd0;
        en_b    = 1'b1;
        sel_b   = 2'd3;
        collect(5);
        check("en_clk", 32'(clk_v), 32'b00101);
        check("en_busy", 32'(busy_v), 32'b01000);

        measure("r2", 1'b0, 1);
        sel_a = 2'd1;
        repeat (64) @(negedge pclk);
        measure("r4", 1'b0, 2);
        sel_a = 2'd2;
        repeat (64) @(negedge pclk);
        measure("r8", 1'b0, 4);
        sel_a = 2'd3;
        repeat (64) @(negedge pclk);
        measure("r16", 1'b0, 8);
        measure("clamp_b", 1'b1, 4);

        wait_fall("sw_fall");
        repeat (5) @(negedge pclk);
        sel_a = 2'd0;
        collect(14);
        check("sw_clk", 32'(clk_v), 32'b00111111110101);
        check("sw_busy", 32'(busy_v), 32'b01111111111000);

        sel_a = 2'd2;
        repeat (20) @(negedge pclk);
        wait_fall("dis_fall");
        @(negedge pclk);
        en_a = 1'b0;
        collect(8);
        check("dis_clk", 32'(clk_v), 32'b00111100);
        check("dis_busy", 32'(busy_v), 32'b01111110);
        any_clk = 1'b0;
        any_stb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            any_clk = any_clk | ca;
`ifdef CLK_DIV_SEL_STB_EN
            any_stb = any_stb | stb_a;
`endif
        end
        check("dis_idle_clk", 32'(any_clk), 32'd0);
`ifdef CLK_DIV_SEL_STB_EN
        check("dis_idle_stb", 32'(any_stb), 32'd0);
`endif
        en_a = 1'b1;
        collect(10);
        check("reen_clk", 32'(clk_v), 32'b0000011110);

        sel_a = 2'd3;
        repeat (40) @(negedge pclk);
        wait_fall("wd_fall");
        @(negedge pclk);
        sel_a = 2'd0;
        @(negedge pclk);
        busy_v = {15'd0, busy_a};
        sel_a  = 2'd3;
        @(negedge pclk);
        busy_v = {busy_v[14:0], busy_a};
        @(negedge pclk);
        busy_v = {busy_v[14:0], busy_a};
        check("wd_busy", 32'(busy_v), 32'b010);
        measure("wd16", 1'b0, 8);

        sel_a = 2'd1;
        repeat (7) @(negedge pclk);
        check("pre_rst_clk", 32'(ca), 32'd1);
        check("pre_rst_busy", 32'(busy_a), 32'd1);
`ifdef CLK_DIV_SEL_STB_EN
        check("pre_rst_stb", 32'(stb_a), 32'd1);
`endif
        #2;
        presetn = 1'b0;
        #1;
        check("arst_clk", 32'(ca), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
`ifdef CLK_DIV_SEL_STB_EN
        check("arst_stb", 32'(stb_a), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_sel.md
# clk_div_sel

Parametrised, glitch-free clock divider/selector for the `pclk` domain. It generates one of `NUM_SEL` power-of-two divided clocks, with ratio 2^(k+1) for selection k. Ratio and enable changes are applied only at period boundaries, so the output never produces a runt pulse. It replaces ripple-divided clocks with a single synchronous counter. A one-cycle strobe is optionally provided for clock-enable style use by downstream APB peripherals.

## Interface
- `NUM_SEL`, default 4: number of selectable ratios (2, 4, … 2^NUM_SEL); range 1..16.
- `SEL_W`, default `$clog2(NUM_SEL)` (minimum 1): width of `sel`.
- `pclk`  in  1  sole clock; all logic is on the rising edge.
- `presetn`  in  1  asynchronous, active-low reset.
- `en`  in  1  divider run request.
- `sel`  in  `SEL_W`  requested ratio index k; ratio = 2^(k+1).
- `clk_out`  out  1  registered divided clock, 50% duty.
- `busy`  out  1  a sel/en request is pending and not yet applied.
- `div_stb`  out  1  one-cycle period-end strobe (only with `CLK_DIV_SEL_STB_EN`).

## Operation
- **State:**
  - free counter `cnt[NUM_SEL-1:0]`;
  - active selection `sel_act`;
  - active enable `en_act`;
  - request registers `sel_req` and `en_req`, which sample `sel`/`en` every cycle.
- **Range clamp:** if `sel >= NUM_SEL`, then `sel_req = NUM_SEL-1`.
- **Running** (`en_act=1`): `cnt` increments and wraps. `clk_out` is a flop loaded with next-`cnt[sel_act]`.
- **Period boundary:** `en_act=1` and `cnt[sel_act:0]` are all ones.
- **Pending:** `sel_req != sel_act` or `en_req != en_act`. `busy` is the registered pending flag.
- **Request application:**
  - Request with `en_act=1`: held until the next period boundary. At that edge `sel_act<=sel_req`, `en_act<=en_req`, `cnt<=0`, `clk_out<=0`. The new ratio's low phase starts on the next cycle.
  - Request with `en_act=0`: applied on the next edge. `cnt` stays 0 and `clk_out` stays 0, so enabling never glitches.
- **Disabled** (`en_act=0`): `cnt` is held at 0 and `clk_out` is 0.
- **Simultaneous sel and en change:** both are applied at the same edge under the rules above. Disable takes precedence, and the new `sel_act` is still latched.
- **Request withdrawn:** if the request returns to the active value before the boundary, nothing is applied and `busy` drops.
- **Reset values:** `cnt=0`, `sel_act=0`, `en_act=0`, `sel_req=0`, `en_req=0`, `clk_out=0`, `busy=0`, `div_stb=0`.

## Timing
- **Output timing:** `clk_out` is glitch-free and registered, never combinational from `sel`. Each high and low phase is exactly 2^k `pclk` cycles.
- **Request sampling:** `sel`/`en` are registered, adding 1 cycle before a request is seen.
- **Switch latency while running:** 2 cycles minimum, up to 2^(sel_act+1)+1 cycles.
- **Enable latency:** 2 cycles from `en` rising to `en_act=1`. The first `clk_out` rise comes 2^k cycles after that.
- **Reset mid-operation:** `presetn` low clears all state immediately (asynchronously), so `clk_out` goes low at once. After release, operation restarts disabled at ratio 2.
- **Wrap-around:** with `sel_act = NUM_SEL-1` the boundary coincides with a full `cnt` wrap.

## Configuration
- **Macro:** `CLK_DIV_SEL_STB_EN`.
- **Defined:**
  - `div_stb` port exists.
  - It is high for exactly one `pclk` cycle in each period-boundary cycle, i.e. the last high cycle of `clk_out`.
  - It is 0 while disabled and in reset.
- **Undefined:** the `div_stb` port and its logic are absent. All other behaviour is identical.

## Structure
- **Package `clk_div_sel_pkg`:**
  - `CLK_DIV_SEL_MAX_SEL` (16);
  - function `clk_div_sel_clamp(sel, num_sel)`;
  - typedef for the sel index.
- **Sub-module `clk_div_sel_cnt`:** counter plus boundary detect, with inputs `run`/`clr`/`sel_act` and outputs `cnt`/`boundary`.
- **Top level:** request/apply control and output flops.

## Test plan
All scenarios use `NUM_SEL=4` and `CLK_DIV_SEL_STB_EN` defined.
- **Reset, then enable:** release reset, `en=1`, `sel=0` → `clk_out` low for 2 cycles of latency, then toggles every cycle (period 2). `busy` pulses high for 1 cycle.
- **Ratio sweep:** `sel`=1, 2, 3 each held for 64 cycles → measured periods 4/8/16. Duty is exactly 50%. `div_stb` appears once per period, in the last high cycle.
- **Mid-period switch:** `sel` 3→0 issued at `cnt=5` → the old 16-cycle period completes (`busy` high ~11 cycles). The first new period is 2 cycles, and there is no runt.
- **Disable mid-period, then re-enable:** `en` 1→0 at `sel=2` mid-period → the period finishes, then `clk_out` stays 0. `en`=1 again → toggling resumes 2 cycles later with a low phase first.
- **Clamp and withdraw:** `sel` driven to 3→0→3 within one period of ratio 16 → no switch occurs, `busy` clears. Out-of-range `sel` (`NUM_SEL=3`, `sel=3`) → ratio 8.
- **Async reset mid-high-phase:** assert `presetn=0` while `clk_out=1` → `clk_out`, `busy` and `div_stb` go to 0 without a `pclk` edge.
